gumnut_exec_ctrl: RTL and testbench

//  Multicycle fetch/decode/writeback sequencer that drives the Gumnut ALU: supplies the IR word and GPR_rs/GPR_r2 operands.

---
 rtl/gumnut_exec_ctrl_if.sv | 10 +
 rtl/gumnut_exec_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_gumnut_exec_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gumnut_exec_ctrl_if.sv
// Instruction-memory fetch channel between the Gumnut sequencer (master) and imem (slave).
interface gumnut_exec_ctrl_if;
  logic [11:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [17:0] imem_data;

  modport master (output imem_addr, imem_req, input imem_ack, imem_data);
  modport slave  (input imem_addr, imem_req, output imem_ack, imem_data);
endinterface

// File: rtl/gumnut_exec_ctrl.sv
// Gumnut multicycle fetch/decode/exec sequencer with 8x8 register file, PC and Z/C flags.
// Optional return stack enabled by defining GUMNUT_RET_STACK_EN.
module gumnut_exec_ctrl #(
  parameter logic [11:0] RESET_PC     = 12'h000,
  parameter int          RSTACK_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  gumnut_exec_ctrl_if.master  imem,
  output logic [17:0]         IR,
  output logic [7:0]          GPR_rs,
  output logic [7:0]          GPR_r2,
  input  logic [7:0]          ALU_result,
  input  logic [7:0]          ALU_shift_result,
  input  logic                alu_c,
  input  logic                resume,
  output logic [11:0]         pc,
  output logic                cc_z,
  output logic                cc_c,
  output logic                retire,
  output logic                unsup,
  output logic                halted
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t             state, state_nx;
  logic [7:0]         rf [8];
  logic [11:0]        pc_inc, br_tgt, exec_pc;
  logic signed [11:0] br_off;
  logic [7:0]         wr_data;
  logic               wr_en, flag_en, unsup_c, halt_go, taken;

`ifdef GUMNUT_RET_STACK_EN
  localparam int SP_W = $clog2(RSTACK_DEPTH);
  logic [11:0]     rstack [RSTACK_DEPTH];
  logic [SP_W-1:0] sp, sp_top;
  logic [SP_W:0]   stk_cnt;
  logic            push, pop;

  assign sp_top = sp - 1'b1;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = RSTACK_DEPTH;
`endif

  assign pc_inc = pc + 12'd1;
  assign br_off = {{4{IR[7]}}, IR[7:0]};
  assign br_tgt = pc_inc + $unsigned(br_off);

  // Instruction decode for the EXEC cycle; prefix-coded opcode classes tested widest first
  always_comb begin
    wr_en   = 1'b0;
    flag_en = 1'b0;
    wr_data = ALU_result;
    exec_pc = pc_inc;
    unsup_c = 1'b0;
    halt_go = 1'b0;
    taken   = 1'b0;
`ifdef GUMNUT_RET_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    if (!IR[17]) begin
      wr_en   = 1'b1;
      flag_en = 1'b1;
    end else if (!IR[16]) begin
      unsup_c = 1'b1;
    end else if (!IR[15]) begin
      wr_en   = 1'b1;
      flag_en = 1'b1;
      wr_data = ALU_shift_result;
    end else if (!IR[14]) begin
      wr_en   = 1'b1;
      flag_en = 1'b1;
    end else if (!IR[13]) begin
      exec_pc = IR[11:0];
`ifdef GUMNUT_RET_STACK_EN
      push    = IR[12];
`endif
    end else if (!IR[12]) begin
      case (IR[11:10])
        2'b00:   taken = cc_z;
        2'b01:   taken = !cc_z;
        2'b10:   taken = cc_c;
        default: taken = !cc_c;
      endcase
      if (taken) exec_pc = br_tgt;
    end else if (!IR[11]) begin
      case (IR[10:8])
        3'b000: begin
`ifdef GUMNUT_RET_STACK_EN
          if (stk_cnt != '0) begin
            pop     = 1'b1;
            exec_pc = rstack[sp_top];
          end else begin
            unsup_c = 1'b1;
          end
`else
          unsup_c = 1'b1;
`endif
        end
        3'b100, 3'b101: halt_go = 1'b1;
        default:        unsup_c = 1'b1;
      endcase
    end else begin
      unsup_c = 1'b1;
    end
  end

  // FSM next state and control outputs
  always_comb begin
    state_nx       = state;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    retire         = 1'b0;
    unsup          = 1'b0;
    halted         = 1'b0;
    case (state)
      S_FETCH: begin
        imem.imem_req = !rst;
        if (imem.imem_ack) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        retire   = 1'b1;
        unsup    = unsup_c;
        state_nx = halt_go ? S_HALT : S_FETCH;
      end
      default: begin
        halted = 1'b1;
        if (resume) state_nx = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      IR     <= '0;
      GPR_rs <= '0;
      GPR_r2 <= '0;
      cc_z   <= 1'b0;
      cc_c   <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_FETCH: if (imem.imem_ack) IR <= imem.imem_data;
        S_DECODE: begin
          GPR_rs <= rf[IR[10:8]];
          GPR_r2 <= rf[IR[7:5]];
        end
        S_EXEC: begin
          // rf[0] is never written so r0 always reads as zero
          if (wr_en && (IR[13:11] != 3'd0)) rf[IR[13:11]] <= wr_data;
          if (flag_en) begin
            cc_z <= (wr_data == 8'd0);
            cc_c <= alu_c;
          end
          pc <= exec_pc;
        end
        default: ;
      endcase
    end
  end

`ifdef GUMNUT_RET_STACK_EN
  // Circular stack: a push when full overwrites the oldest entry, count saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp      <= '0;
      stk_cnt <= '0;
    end else if (state == S_EXEC) begin
      if (push) begin
        sp <= sp + 1'b1;
        if (stk_cnt != (SP_W+1)'(RSTACK_DEPTH)) stk_cnt <= stk_cnt + 1'b1;
      end else if (pop) begin
        sp      <= sp_top;
        stk_cnt <= stk_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_EXEC) && push) rstack[sp] <= pc_inc;
  end
`endif

endmodule

// File: tb/tb_gumnut_exec_ctrl.sv
// Scoreboard bench for gumnut_exec_ctrl: directed instruction stream, monitor checks each retire.
module tb_gumnut_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] IR;
  logic [7:0]  GPR_rs, GPR_r2;
  logic [7:0]  alu_res = 8'h00, alu_sh = 8'h00;
  logic        alu_c = 1'b0, resume = 1'b0;
  logic [11:0] pc, pcv;
  logic        cc_z, cc_c, retire, unsup, halted;

  always #5 clk = ~clk;

  gumnut_exec_ctrl_if imem();

  gumnut_exec_ctrl #(.RESET_PC(12'h000), .RSTACK_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .imem(imem), .IR(IR), .GPR_rs(GPR_rs), .GPR_r2(GPR_r2),
    .ALU_result(alu_res), .ALU_shift_result(alu_sh), .alu_c(alu_c), .resume(resume),
    .pc(pc), .cc_z(cc_z), .cc_c(cc_c), .retire(retire), .unsup(unsup), .halted(halted)
  );

  typedef struct {
    logic [11:0] pc;
    logic        un;
    logic [7:0]  rs;
    logic [7:0]  r2;
    logic [17:0] ir;
    logic [11:0] npc;
    logic        z;
    logic        c;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] p, input logic u, input logic [7:0] a,
                              input logic [7:0] b, input logic [11:0] n, input logic z,
                              input logic c);
    exp_t e;
    e.pc = p; e.un = u; e.rs = a; e.r2 = b; e.ir = '0; e.npc = n; e.z = z; e.c = c;
    return e;
  endfunction

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem.imem_req !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL req_timeout: got imem_req=%0b expected 1 within 50 cycles", imem.imem_req);
        finish_run();
        return;
      end
    end
  endtask

  task automatic run(input logic [17:0] ins, input logic [7:0] res, input logic [7:0] sh,
                     input logic c, input exp_t e, input bit halts);
    int n;
    wait_req();
    chk("imem_addr", imem.imem_addr, e.pc);
    e.ir           = ins;
    imem.imem_data = ins;
    imem.imem_ack  = 1'b1;
    alu_res        = res;
    alu_sh         = sh;
    alu_c          = c;
    sbq.push_back(e);
    @(negedge clk);
    imem.imem_ack = 1'b0;
    if (!halts) begin
      n = 1;
      while (imem.imem_req !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("ack_to_req", n, 3);
    end
  endtask

  // Monitor: on each retire pop the expectation, check operands now and results one cycle later
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (retire === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got retire at pc=%0h expected none", pc);
        end else begin
          e = sbq.pop_front();
          chk("ret_pc", pc, e.pc);
          chk("ret_unsup", unsup, e.un);
          chk("ret_gpr_rs", GPR_rs, e.rs);
          chk("ret_gpr_r2", GPR_r2, e.r2);
          chk("ret_ir", IR, e.ir);
          @(negedge clk);
          chk("next_pc", pc, e.npc);
          chk("cc_z", cc_z, e.z);
          chk("cc_c", cc_c, e.c);
        end
      end
    end
  end

  initial begin
    imem.imem_ack  = 1'b0;
    imem.imem_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem.imem_req, 0);
    chk("rst_pc", pc, 12'h000);
    chk("rst_ir", IR, 0);
    chk("rst_gpr", {GPR_rs, GPR_r2}, 0);
    chk("rst_ctl", {cc_z, cc_c, retire, unsup, halted}, 0);
    rst = 1'b0;

    run(18'h00805, 8'h05, 8'h00, 1'b0, mk(12'h000, 0, 8'h00, 8'h00, 12'h001, 0, 0), 0);
    run(18'h08105, 8'h00, 8'h00, 1'b0, mk(12'h001, 0, 8'h05, 8'h00, 12'h002, 1, 0), 0);
    run(18'h3E003, 8'h00, 8'h00, 1'b0, mk(12'h002, 0, 8'h00, 8'h00, 12'h006, 1, 0), 0);
    run(18'h00007, 8'h07, 8'h00, 1'b1, mk(12'h006, 0, 8'h00, 8'h00, 12'h007, 0, 1), 0);
    run(18'h3E003, 8'h00, 8'h00, 1'b0, mk(12'h007, 0, 8'h00, 8'h00, 12'h008, 0, 1), 0);
    run(18'h3E8FE, 8'h00, 8'h00, 1'b0, mk(12'h008, 0, 8'h00, 8'h00, 12'h007, 0, 1), 0);
    run(18'h31900, 8'h11, 8'hA0, 1'b0, mk(12'h007, 0, 8'h05, 8'h00, 12'h008, 0, 0), 0);
    run(18'h3A320, 8'hA5, 8'h00, 1'b1, mk(12'h008, 0, 8'hA0, 8'h05, 12'h009, 0, 1), 0);
    run(18'h24321, 8'h00, 8'h00, 1'b0, mk(12'h009, 1, 8'hA0, 8'h05, 12'h00A, 0, 1), 0);
    run(18'h3D040, 8'h00, 8'h00, 1'b0, mk(12'h00A, 0, 8'h00, 8'h00, 12'h040, 0, 1), 0);
`ifdef GUMNUT_RET_STACK_EN
    run(18'h3F000, 8'h00, 8'h00, 1'b0, mk(12'h040, 0, 8'h00, 8'h00, 12'h00B, 0, 1), 0);
    pcv = 12'h00B;
`else
    run(18'h3F000, 8'h00, 8'h00, 1'b0, mk(12'h040, 1, 8'h00, 8'h00, 12'h041, 0, 1), 0);
    pcv = 12'h041;
`endif
    run(18'h3F000, 8'h00, 8'h00, 1'b0, mk(pcv, 1, 8'h00, 8'h00, pcv + 12'd1, 0, 1), 0);
    run(18'h3CFFF, 8'h00, 8'h00, 1'b0, mk(pcv + 12'd1, 0, 8'h00, 8'h00, 12'hFFF, 0, 1), 0);
    run(18'h20000, 8'h00, 8'h00, 1'b0, mk(12'hFFF, 1, 8'h00, 8'h00, 12'h000, 0, 1), 0);
    run(18'h3F600, 8'h00, 8'h00, 1'b0, mk(12'h000, 1, 8'h00, 8'h00, 12'h001, 0, 1), 0);
    run(18'h3F800, 8'h00, 8'h00, 1'b0, mk(12'h001, 1, 8'h00, 8'h00, 12'h002, 0, 1), 0);
    run(18'h3F100, 8'h00, 8'h00, 1'b0, mk(12'h002, 1, 8'h05, 8'h00, 12'h003, 0, 1), 0);
    run(18'h3E405, 8'h00, 8'h00, 1'b0, mk(12'h003, 0, 8'hA5, 8'h00, 12'h009, 0, 1), 0);

    // wait: sits in HALT, ignores a stray ack, then resumes at the next pc
    run(18'h3F400, 8'h00, 8'h00, 1'b0, mk(12'h009, 0, 8'hA5, 8'h00, 12'h00A, 0, 1), 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", {halted, imem.imem_req}, 2'b10);
      if (i == 4) begin
        imem.imem_data = 18'h3FFFF;
        imem.imem_ack  = 1'b1;
      end else begin
        imem.imem_ack = 1'b0;
      end
      @(negedge clk);
    end
    chk("halt_ir", IR, 18'h3F400);
    chk("halt_pc", pc, 12'h00A);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_req", imem.imem_req, 1);
    chk("resume_addr", imem.imem_addr, 12'h00A);

    run(18'h3F500, 8'h00, 8'h00, 1'b0, mk(12'h00A, 0, 8'h00, 8'h00, 12'h00B, 0, 1), 1);
    repeat (2) @(negedge clk);
    chk("stby_halted", halted, 1);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;

    // Reset during EXEC of add r2,r0,#9 abandons it
    wait_req();
    chk("imem_addr", imem.imem_addr, 12'h00B);
    imem.imem_data = 18'h01009;
    imem.imem_ack  = 1'b1;
    alu_res        = 8'h09;
    alu_c          = 1'b0;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pc", pc, 12'h000);
    chk("mid_rst_flags", {cc_z, cc_c}, 0);
    chk("mid_rst_ctl", {retire, halted, imem.imem_req}, 0);
    imem.imem_data = 18'h3FFFF;
    imem.imem_ack  = 1'b1;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    chk("mid_rst_ir", IR, 0);
    rst = 1'b0;

    run(18'h00220, 8'h33, 8'h00, 1'b1, mk(12'h000, 0, 8'h00, 8'h00, 12'h001, 0, 1), 0);

    repeat (5) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    finish_run();
  end

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    finish_run();
  end
endmodule
